golden_nonce_uart_tx: RTL and testbench

//  Return path from miner to host. Queues golden nonces from the miner control unit
//  (rx_new_nonce / rx_golden_nonce pair) and serialises each one as 4 UART 8N1 bytes on
//  tx_serial. This is the transmit counterpart of the comm block's host->FPGA work path.

---
 rtl/golden_nonce_uart_tx_pkg.sv | 19 +
 rtl/golden_nonce_uart_tx_if.sv | 21 ++
 rtl/golden_nonce_uart_tx_fifo.sv | 70 +++++++
 rtl/golden_nonce_uart_tx.sv | 156 +++++++++++++++
 tb/tb_golden_nonce_uart_tx.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/golden_nonce_uart_tx_pkg.sv
// Shared constants and types for the golden-nonce UART return path.
package golden_nonce_uart_tx_pkg;

   localparam int unsigned NONCE_W              = 32;
   localparam int unsigned UART_BYTES_PER_NONCE = 4;
   localparam int unsigned BITS_PER_BYTE        = 8;
   localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

   typedef logic [NONCE_W-1:0] nonce_t;

   // 2-bit frame state encoding, common with the comm receiver.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/golden_nonce_uart_tx_if.sv
// Nonce-in / UART-out bundle between the miner control unit and the transmitter.
interface golden_nonce_uart_tx_if #(
   parameter int unsigned FIFO_DEPTH_LOG2 = 2
);
   logic                     rx_new_nonce;
   logic [31:0]              rx_golden_nonce;
   logic                     tx_serial;
   logic                     tx_busy;
   logic [FIFO_DEPTH_LOG2:0] tx_fifo_level;
   logic [7:0]               tx_dropped_count;

   modport master (
      output rx_new_nonce, rx_golden_nonce,
      input  tx_serial, tx_busy, tx_fifo_level, tx_dropped_count
   );

   modport slave (
      input  rx_new_nonce, rx_golden_nonce,
      output tx_serial, tx_busy, tx_fifo_level, tx_dropped_count
   );
endinterface

// File: rtl/golden_nonce_uart_tx_fifo.sv
// Synchronous show-ahead FIFO; full/empty from pointers carrying an extra wrap bit.
module golden_nonce_uart_tx_fifo #(
   parameter int unsigned DEPTH_LOG2 = 2,
   parameter int unsigned WIDTH      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  logic [WIDTH-1:0]      din_i,
   input  logic                  pop_i,
   output logic [WIDTH-1:0]      dout_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [DEPTH_LOG2:0]   level_o
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned AW    = DEPTH_LOG2;
   localparam int unsigned PW    = DEPTH_LOG2 + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    level_q,  level_d;
   logic             full_c, empty_c, do_push_c, do_pop_c;

   assign full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_c   = (wr_ptr_q == rd_ptr_q);
   assign do_pop_c  = pop_i && !empty_c;
   // A pop on the same edge frees a slot, so a push into a full FIFO is still accepted.
   assign do_push_c = push_i && (!full_c || do_pop_c);

   // Pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push_c, do_pop_c})
         2'b10:   level_d = level_q + PW'(1);
         2'b01:   level_d = level_q - PW'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointer and occupancy registers; reset discards contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array write.
   always_ff @(posedge clk) begin
      if (do_push_c) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

   assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign full_o  = full_c;
   assign empty_o = empty_c;
   assign level_o = level_q;

endmodule

// File: rtl/golden_nonce_uart_tx.sv
// Queues golden nonces and sends each as four little-endian UART 8N1 bytes.
module golden_nonce_uart_tx
   import golden_nonce_uart_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
   parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
   input  logic                   hash_clk,
   input  logic                   reset_n,
   golden_nonce_uart_tx_if.slave  bus
);

   localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned LW = FIFO_DEPTH_LOG2 + 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    BIT_LAST   = 3'(BITS_PER_BYTE - 1);
   localparam logic [1:0]    BYTE_LAST  = 2'(UART_BYTES_PER_NONCE - 1);

   tx_state_e     state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   nonce_t        shift_q, shift_d;
   logic          tx_q, tx_d;
   logic [7:0]    drop_q, drop_d;

   logic          bit_done_c;
   logic          pop_c;
   nonce_t        fifo_dout;
   logic          fifo_full, fifo_empty;
   logic [LW-1:0] fifo_level;

   golden_nonce_uart_tx_fifo #(
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
      .WIDTH      (NONCE_W)
   ) u_fifo (
      .clk     (hash_clk),
      .rst_n   (reset_n),
      .push_i  (bus.rx_new_nonce),
      .din_i   (bus.rx_golden_nonce),
      .pop_i   (pop_c),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign bit_done_c = (timer_q == TIMER_LAST);

   // Frame state register.
   always_ff @(posedge hash_clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Frame sequencing: start bit, 8 data bits, stop bit, four bytes per nonce.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (!fifo_empty) state_d = ST_START;
         ST_START: if (bit_done_c) state_d = ST_DATA;
         ST_DATA:  if (bit_done_c && (bit_idx_q == BIT_LAST)) state_d = ST_STOP;
         ST_STOP: begin
            if (bit_done_c) begin
               if ((byte_idx_q != BYTE_LAST) || !fifo_empty) state_d = ST_START;
               else                                           state_d = ST_IDLE;
            end
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath next values: bit timer, counters, shift register, line level, pop, drops.
   always_comb begin
      timer_d    = bit_done_c ? '0 : timer_q + TW'(1);
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      pop_c      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            tx_d    = 1'b1;
            if (!fifo_empty) begin
               pop_c      = 1'b1;
               shift_d    = fifo_dout;
               byte_idx_d = '0;
               tx_d       = 1'b0;
            end
         end
         ST_START: begin
            if (bit_done_c) begin
               bit_idx_d = '0;
               tx_d      = shift_q[0];
            end
         end
         ST_DATA: begin
            if (bit_done_c) begin
               shift_d = shift_q >> 1;
               if (bit_idx_q == BIT_LAST) begin
                  tx_d = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = shift_q[1];
               end
            end
         end
         ST_STOP: begin
            if (bit_done_c) begin
               if (byte_idx_q != BYTE_LAST) begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  tx_d       = 1'b0;
               end else if (!fifo_empty) begin
                  pop_c      = 1'b1;
                  shift_d    = fifo_dout;
                  byte_idx_d = '0;
                  tx_d       = 1'b0;
               end else begin
                  tx_d = 1'b1;
               end
            end
         end
         default: tx_d = 1'b1;
      endcase

      drop_d = drop_q;
      if (bus.rx_new_nonce && fifo_full && !pop_c && (drop_q != 8'hFF))
         drop_d = drop_q + 8'd1;
   end

   // Datapath registers; line idles high, including straight out of reset.
   always_ff @(posedge hash_clk or negedge reset_n) begin
      if (!reset_n) begin
         timer_q    <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         drop_q     <= '0;
      end else begin
         timer_q    <= timer_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         drop_q     <= drop_d;
      end
   end

   assign bus.tx_serial        = tx_q;
   assign bus.tx_busy          = (state_q != ST_IDLE) || (fifo_level != '0);
   assign bus.tx_fifo_level    = fifo_level;
   assign bus.tx_dropped_count = drop_q;

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Bench for golden_nonce_uart_tx: frame-timing reference model plus directed/random scenarios.
module tb_golden_nonce_uart_tx;

   localparam int unsigned CPB    = 4;
   localparam int unsigned L2     = 2;
   localparam int          DEPTH  = 4;
   localparam int          BYTE_T = 10 * CPB;
   localparam int          FRAME  = 4 * BYTE_T;

   logic hash_clk = 1'b0;
   logic reset_n;
   always #5 hash_clk = ~hash_clk;

   golden_nonce_uart_tx_if #(.FIFO_DEPTH_LOG2(L2)) bus ();

   golden_nonce_uart_tx #(
      .CLKS_PER_BIT    (CPB),
      .FIFO_DEPTH_LOG2 (L2)
   ) dut (
      .hash_clk (hash_clk),
      .reset_n  (reset_n),
      .bus      (bus)
   );

   // Reference model: queued nonces, the nonce on the line, and when its frame started/ends.
   logic [31:0] m_fifo[$];
   logic [31:0] m_cur;
   int          m_start;
   int          m_free;
   int          m_drops;
   int          edge_n;
   int          n_chk;
   int          n_fail;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected line level after the current edge, from frame position arithmetic.
   function automatic logic m_tx();
      int o, b, slot;
      if (edge_n >= m_free) return 1'b1;
      o    = edge_n - m_start;
      b    = o / BYTE_T;
      slot = (o % BYTE_T) / CPB;
      if (slot == 0) return 1'b0;
      if (slot == 9) return 1'b1;
      return m_cur[b*8 + slot - 1];
   endfunction

   function automatic logic m_busy();
      return (edge_n < m_free) || (m_fifo.size() > 0);
   endfunction

   task automatic model_edge(input bit nv, input logic [31:0] v);
      bit pop, acc;
      edge_n++;
      pop = (m_fifo.size() > 0) && (edge_n >= m_free);
      acc = 1'b0;
      if (nv) begin
         if ((m_fifo.size() < DEPTH) || pop) acc = 1'b1;
         else if (m_drops < 255)             m_drops++;
      end
      if (pop) begin
         m_cur   = m_fifo.pop_front();
         m_start = edge_n;
         m_free  = edge_n + FRAME;
      end
      if (acc) m_fifo.push_back(v);
   endtask

   task automatic check_all();
      chk("tx_serial", 32'(bus.tx_serial), 32'(m_tx()));
      chk("tx_busy", 32'(bus.tx_busy), 32'(m_busy()));
      chk("tx_fifo_level", 32'(bus.tx_fifo_level), 32'(m_fifo.size()));
      chk("tx_dropped_count", 32'(bus.tx_dropped_count), 32'(m_drops));
   endtask

   // One clock: drive inputs, model the edge, then compare on the falling edge.
   task automatic cycle(input bit nv, input logic [31:0] v);
      bus.rx_new_nonce    = nv;
      bus.rx_golden_nonce = v;
      @(posedge hash_clk);
      model_edge(nv, v);
      @(negedge hash_clk);
      bus.rx_new_nonce = 1'b0;
      check_all();
   endtask

   task automatic drain();
      for (int i = 0; i < 8 * FRAME && m_busy(); i++) cycle(1'b0, $urandom);
      chk("drain_idle", 32'(bus.tx_busy), 32'd0);
   endtask

   // Send one nonce from idle and decode it with a mid-bit UART sampler.
   task automatic send_decode(input logic [31:0] v);
      logic [9:0] fr [4];
      logic [7:0] exp_b;
      cycle(1'b1, v);
      chk("pre_fall_line", 32'(bus.tx_serial), 32'd1);
      for (int k = 0; k < FRAME; k++) begin
         cycle(1'b0, $urandom);
         if (k == 0) chk("fall_latency", 32'(bus.tx_serial), 32'd0);
         if ((k % CPB) == CPB / 2) fr[k / BYTE_T][(k % BYTE_T) / CPB] = bus.tx_serial;
      end
      chk("busy_last_cycle", 32'(bus.tx_busy), 32'd1);
      cycle(1'b0, $urandom);
      chk("busy_drop", 32'(bus.tx_busy), 32'd0);
      for (int b = 0; b < 4; b++) begin
         exp_b = 8'(v >> (8 * b));
         chk("uart_start", 32'(fr[b][0]), 32'd0);
         chk("uart_stop", 32'(fr[b][9]), 32'd1);
         chk("uart_byte", 32'(fr[b][8:1]), 32'(exp_b));
      end
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      edge_n = 0; m_free = 0; m_start = 0; m_drops = 0; m_cur = '0;
      bus.rx_new_nonce = 1'b0;
      bus.rx_golden_nonce = '0;
      reset_n = 1'b0;
      repeat (3) @(negedge hash_clk);
      chk("rst_tx_serial", 32'(bus.tx_serial), 32'd1);
      chk("rst_tx_busy", 32'(bus.tx_busy), 32'd0);
      chk("rst_level", 32'(bus.tx_fifo_level), 32'd0);
      chk("rst_drops", 32'(bus.tx_dropped_count), 32'd0);
      reset_n = 1'b1;
      repeat (2) cycle(1'b0, $urandom);

      // Single nonce, byte order and latency.
      send_decode(32'h12345678);
      repeat (3) cycle(1'b0, $urandom);

      // Three consecutive captures go out back to back.
      cycle(1'b1, 32'hA0A0A0A0);
      cycle(1'b1, 32'hB1B1B1B1);
      cycle(1'b1, 32'hC2C2C2C2);
      while (edge_n < m_start + FRAME - 1) cycle(1'b0, $urandom);
      cycle(1'b0, $urandom);
      chk("no_gap_start", 32'(bus.tx_serial), 32'd0);
      drain();

      // Seven pulses while busy: one in flight, four queued, two dropped.
      for (int i = 0; i < 7; i++) cycle(1'b1, $urandom);
      chk("drops_after_7", 32'(bus.tx_dropped_count), 32'd2);
      chk("level_full", 32'(bus.tx_fifo_level), 32'd4);

      // Push while full on the same edge as the pop.
      for (int i = 0; i < 2 * FRAME && (edge_n + 1 < m_free); i++) cycle(1'b0, $urandom);
      cycle(1'b1, $urandom);
      chk("pushpop_level", 32'(bus.tx_fifo_level), 32'd4);
      chk("pushpop_drops", 32'(bus.tx_dropped_count), 32'd2);
      drain();

      // Random traffic.
      for (int i = 0; i < 600; i++) cycle(($urandom_range(0, 9) == 0), $urandom);
      drain();

      // Reset in the middle of byte 2's data bits, with entries queued.
      cycle(1'b1, $urandom);
      cycle(1'b1, $urandom);
      cycle(1'b1, $urandom);
      for (int i = 0; i < FRAME && (edge_n < m_start + 100); i++) cycle(1'b0, $urandom);
      chk("pre_rst_level", 32'(bus.tx_fifo_level), 32'd2);
      #1 reset_n = 1'b0;
      #1;
      chk("midrst_tx_serial", 32'(bus.tx_serial), 32'd1);
      chk("midrst_level", 32'(bus.tx_fifo_level), 32'd0);
      chk("midrst_drops", 32'(bus.tx_dropped_count), 32'd0);
      chk("midrst_busy", 32'(bus.tx_busy), 32'd0);
      m_fifo.delete();
      m_drops = 0;
      m_free  = edge_n;
      repeat (2) @(negedge hash_clk);
      reset_n = 1'b1;
      cycle(1'b0, $urandom);
      send_decode(32'hDEADBEEF);

      // Sustained overflow saturates the drop counter.
      for (int i = 0; i < 330; i++) cycle(1'b1, $urandom);
      chk("drops_saturated", 32'(bus.tx_dropped_count), 32'hFF);
      cycle(1'b1, $urandom);
      chk("drops_no_wrap", 32'(bus.tx_dropped_count), 32'hFF);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
